// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller (package pipe_pkg).
// Mult/div FSM states, EX forward-select encodings, default latencies and match helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;

  // Register $0 never creates a dependency, and an unused source field is ignored.
  function automatic logic src_match(logic [4:0] dst, logic [4:0] src, logic use_src);
    return use_src && (src != 5'd0) && (dst == src);
  endfunction

  // The MEM stage beats WB because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(logic [4:0] src, logic [4:0] mem_rd, logic mem_alu_wr,
                                         logic [4:0] wb_rd, logic wb_regwre);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_alu_wr && (src != 5'd0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwre && (src != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: the pipeline (master) supplies stage
// register indices and flags, the controller (slave) returns stalls, flushes and selects.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_is_branch;
  logic       id_reads_hilo;
  logic       id_is_muldiv;
  logic       pc_taken;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] ex_rd;
  logic       ex_regwre;
  logic       ex_memrd;
  logic       ex_is_muldiv;
  logic       ex_is_div;
  logic [4:0] mem_rd;
  logic       mem_regwre;
  logic       mem_memrd;
  logic [4:0] wb_rd;
  logic       wb_regwre;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       id_fwd_a;
  logic       id_fwd_b;
  logic       md_start;
  logic       md_busy;
  logic       hilo_we;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_reads_hilo, id_is_muldiv,
           pc_taken, ex_rs, ex_rt, ex_rd, ex_regwre, ex_memrd, ex_is_muldiv, ex_is_div,
           mem_rd, mem_regwre, mem_memrd, wb_rd, wb_regwre,
    input  pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, id_fwd_a, id_fwd_b,
           md_start, md_busy, hilo_we
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_reads_hilo, id_is_muldiv,
           pc_taken, ex_rs, ex_rt, ex_rd, ex_regwre, ex_memrd, ex_is_muldiv, ex_is_div,
           mem_rd, mem_regwre, mem_memrd, wb_rd, wb_regwre,
    output pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, id_fwd_a, id_fwd_b,
           md_start, md_busy, hilo_we
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_muldiv_seq.sv
// Multi-cycle HI/LO mult/div sequencer: IDLE -> BUSY (latency countdown) -> DONE (hilo_we).
// A start request outside IDLE is ignored; reset aborts the operation without a write.
module muldiv_seq
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_is_muldiv_i,
  input  logic ex_is_div_i,
  output logic md_start_o,
  output logic md_busy_o,
  output logic hilo_we_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The <= test keeps the counter from wrapping even if it ever reads zero in BUSY.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    md_start_o = 1'b0;
    hilo_we_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_is_muldiv_i && rst) begin
          md_start_o = 1'b1;
          state_d    = BUSY;
          count_d    = ex_is_div_i ? DIV_CNT : MUL_CNT;
        end
      end
      BUSY: begin
        if (count_q <= ONE_CNT) begin
          state_d = DONE;
          count_d = '0;
        end else begin
          count_d = count_q - ONE_CNT;
        end
      end
      DONE: begin
        hilo_we_o = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign md_busy_o = (state_q != IDLE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage CPU: stalls, flushes, EX/ID forwarding.
// Optional macro HAZARD_ID_FWD_EN enables MEM->ID forwarding for branch compares.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  logic mem_alu_wr;
  logic ex_hit;
  logic mem_hit_a;
  logic mem_hit_b;
  logic load_use;
  logic branch_ex;
  logic branch_mem_ld;
  logic branch_mem_alu;
  logic hilo_stall;
  logic stall;
  logic id_fwd_a_raw;
  logic id_fwd_b_raw;
  logic md_busy;
  logic md_start;
  logic hilo_we;

  assign mem_alu_wr = hz.mem_regwre & ~hz.mem_memrd;
  assign ex_hit     = src_match(hz.ex_rd, hz.id_rs, hz.id_use_rs)
                    | src_match(hz.ex_rd, hz.id_rt, hz.id_use_rt);
  assign mem_hit_a  = src_match(hz.mem_rd, hz.id_rs, hz.id_use_rs);
  assign mem_hit_b  = src_match(hz.mem_rd, hz.id_rt, hz.id_use_rt);

  assign load_use      = hz.ex_memrd & ex_hit;
  assign branch_ex     = hz.id_is_branch & hz.ex_regwre & ex_hit;
  assign branch_mem_ld = hz.id_is_branch & hz.mem_memrd & (mem_hit_a | mem_hit_b);

`ifdef HAZARD_ID_FWD_EN
  assign branch_mem_alu = 1'b0;
  assign id_fwd_a_raw   = mem_alu_wr & mem_hit_a;
  assign id_fwd_b_raw   = mem_alu_wr & mem_hit_b;
`else
  // Without the ID bypass the compare must wait for the MEM ALU result to reach WB.
  assign branch_mem_alu = hz.id_is_branch & mem_alu_wr & (mem_hit_a | mem_hit_b);
  assign id_fwd_a_raw   = 1'b0;
  assign id_fwd_b_raw   = 1'b0;
`endif

  // md_busy covers DONE as well, so a dependent mfhi waits until HI/LO is written.
  assign hilo_stall = (hz.id_reads_hilo | hz.id_is_muldiv) & (hz.ex_is_muldiv | md_busy);
  assign stall      = load_use | branch_ex | branch_mem_ld | branch_mem_alu | hilo_stall;

  // While in reset, freeze the front end and bubble both IF/ID and ID/EX.
  assign hz.pc_en      = rst & ~stall;
  assign hz.ifid_en    = rst & ~stall;
  assign hz.idex_flush = ~rst | stall;
  assign hz.ifid_flush = ~rst | (hz.pc_taken & ~stall);

  assign hz.fwd_a    = rst ? fwd_sel(hz.ex_rs, hz.mem_rd, mem_alu_wr, hz.wb_rd, hz.wb_regwre) : FWD_RF;
  assign hz.fwd_b    = rst ? fwd_sel(hz.ex_rt, hz.mem_rd, mem_alu_wr, hz.wb_rd, hz.wb_regwre) : FWD_RF;
  assign hz.id_fwd_a = rst & id_fwd_a_raw;
  assign hz.id_fwd_b = rst & id_fwd_b_raw;

  muldiv_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_muldiv_seq (
    .clk           (clk),
    .rst           (rst),
    .ex_is_muldiv_i(hz.ex_is_muldiv),
    .ex_is_div_i   (hz.ex_is_div),
    .md_start_o    (md_start),
    .md_busy_o     (md_busy),
    .hilo_we_o     (hilo_we)
  );

  assign hz.md_start = md_start;
  assign hz.md_busy  = md_busy;
  assign hz.hilo_we  = hilo_we;

endmodule
